// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, response codes, wait counter
// width and a helper that sizes word-address buses from a memory depth.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_t;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  localparam int WAIT_CNT_W = 4;

  // Bits needed to index 'depth' words; never less than one.
  function automatic int addr_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_byte_mem.sv
// Byte-enabled word RAM: synchronous write with per-byte enables,
// combinational read so the caller can register the data on the access edge.
module apb_byte_mem
  import apb_pkg::*;
#(
  parameter int DATA_width = 32,
  parameter int MEM_depth  = 64
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [DATA_width/8-1:0]         be,
  input  logic [addr_bits(MEM_depth)-1:0] addr,
  input  logic [DATA_width-1:0]           wdata,
  output logic [DATA_width-1:0]           rdata
);

  localparam int NB = DATA_width / 8;

  logic [DATA_width-1:0] mem [MEM_depth];

  // Byte-granular write: only lanes with their enable set are updated.
  // NOTE: the array has no reset; clearing a RAM needs a per-word sequencer
  // and blocks mapping onto memory macros, so contents start undefined.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/apb_wait_mem_slave.sv
// APB4 memory slave with configurable width/depth, byte strobes,
// programmable wait states and SLVERR on out-of-range word addresses.
module apb_wait_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_width  = 8,
  parameter int DATA_width  = 32,
  parameter int MEM_depth   = 64,
  parameter int WAIT_states = 0
) (
  input  logic                    P_clk,
  input  logic                    P_reset_n,
  input  logic                    P_sel,
  input  logic                    P_enable,
  input  logic                    P_write,
  input  logic [ADDR_width-1:0]   P_addr,
  input  logic [DATA_width-1:0]   P_wdata,
  input  logic [DATA_width/8-1:0] P_strb,
  output logic [DATA_width-1:0]   P_rdata,
  output logic                    P_ready,
  output logic                    P_slverr
);

  localparam int MEM_AW = addr_bits(MEM_depth);
  localparam logic [ADDR_width:0] DEPTH_L = (ADDR_width+1)'(MEM_depth);

  // Reject unusable parameter combinations while elaborating.
  if ((DATA_width % 8) != 0 || DATA_width < 8 || ADDR_width < 1 ||
      MEM_depth < 1 || 64'(MEM_depth) > (64'd1 << ADDR_width) ||
      WAIT_states < 0 || WAIT_states > 15) begin : g_param_check
    $error("apb_wait_mem_slave: illegal parameter combination");
  end

  apb_state_t            state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  slverr_q, slverr_d;
  logic [DATA_width-1:0] rdata_q, rdata_d;

  logic                  do_access;
  logic                  in_range;
  logic                  mem_we;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_width-1:0] mem_rdata;

  assign in_range = ({1'b0, P_addr} < DEPTH_L);
  assign mem_addr = P_addr[MEM_AW-1:0];
  assign mem_we   = do_access && P_write && in_range;

  apb_byte_mem #(
    .DATA_width(DATA_width),
    .MEM_depth (MEM_depth)
  ) u_mem (
    .clk  (P_clk),
    .we   (mem_we),
    .be   (P_strb),
    .addr (mem_addr),
    .wdata(P_wdata),
    .rdata(mem_rdata)
  );

  // State, wait counter and registered bus outputs.
  // NOTE: clocked state uses <= so every register samples pre-edge values;
  // blocking = here would make results depend on statement order.
  always_ff @(posedge P_clk or negedge P_reset_n) begin
    if (!P_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      slverr_q <= APB_RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state, wait counting and access/response decode.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = 1'b0;
    slverr_d  = APB_RESP_OKAY;
    rdata_d   = rdata_q;
    do_access = 1'b0;

    case (state_q)
      IDLE: begin
        if (P_sel && P_enable) begin
          if (WAIT_states == 0) begin
            do_access = 1'b1;
          end else begin
            cnt_d   = WAIT_CNT_W'(WAIT_states - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!P_sel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          do_access = 1'b1;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_access) begin
      state_d  = RESP;
      ready_d  = 1'b1;
      slverr_d = in_range ? APB_RESP_OKAY : APB_RESP_ERR;
      if (!P_write) begin
        rdata_d = in_range ? mem_rdata : '0;
      end
    end
  end

  assign P_ready  = ready_q;
  assign P_slverr = slverr_q;
  assign P_rdata  = rdata_q;

endmodule

// File: tb/tb_apb_wait_mem_slave.sv
// Scoreboard bench for apb_wait_mem_slave: three instances (0, 3 and 4 wait
// states) share the bus; the driver pushes expected responses, a monitor
// pops and compares them whenever an instance raises P_ready.
module tb_apb_wait_mem_slave;

  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  logic            P_clk = 1'b0;
  logic            P_reset_n = 1'b1;
  logic [2:0]      sel;
  logic            P_enable;
  logic            P_write;
  logic [7:0]      P_addr;
  logic [31:0]     P_wdata;
  logic [3:0]      P_strb;
  logic [2:0]      rdy;
  logic [2:0]      err;
  logic [2:0][31:0] rd;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] last_rd [3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 P_clk = ~P_clk;

  always @(posedge P_clk) cyc <= cyc + 1;

  apb_wait_mem_slave #(.ADDR_width(8), .DATA_width(32), .MEM_depth(64), .WAIT_states(0)) u_w0 (
    .P_clk(P_clk), .P_reset_n(P_reset_n), .P_sel(sel[0]), .P_enable(P_enable),
    .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_strb(P_strb),
    .P_rdata(rd[0]), .P_ready(rdy[0]), .P_slverr(err[0]));

  apb_wait_mem_slave #(.ADDR_width(8), .DATA_width(32), .MEM_depth(64), .WAIT_states(3)) u_w3 (
    .P_clk(P_clk), .P_reset_n(P_reset_n), .P_sel(sel[1]), .P_enable(P_enable),
    .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_strb(P_strb),
    .P_rdata(rd[1]), .P_ready(rdy[1]), .P_slverr(err[1]));

  apb_wait_mem_slave #(.ADDR_width(8), .DATA_width(32), .MEM_depth(64), .WAIT_states(4)) u_w4 (
    .P_clk(P_clk), .P_reset_n(P_reset_n), .P_sel(sel[2]), .P_enable(P_enable),
    .P_write(P_write), .P_addr(P_addr), .P_wdata(P_wdata), .P_strb(P_strb),
    .P_rdata(rd[2]), .P_ready(rdy[2]), .P_slverr(err[2]));

  function automatic int wait_of(input int id);
    case (id)
      0:       return 0;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One complete APB transfer on instance 'id'; the expected response is
  // queued at A0 together with the cycle in which P_ready must appear.
  task automatic xfer(input int id, input logic wr, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    int   n;
    @(posedge P_clk); #1;
    sel[id]  = 1'b1;
    P_enable = 1'b0;
    P_write  = wr;
    P_addr   = a;
    P_wdata  = wd;
    P_strb   = st;
    @(posedge P_clk); #1;
    P_enable = 1'b1;
    if (!wr) last_rd[id] = exp_rd;
    e.id    = id;
    e.err   = exp_err;
    e.rdata = last_rd[id];
    e.cyc   = cyc + wait_of(id) + 1;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge P_clk);
      n++;
    end while (rdy[id] !== 1'b1 && n < 40);
    if (rdy[id] !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout dut%0d: P_ready=%b after 40 cycles, expected 1", id, rdy[id]);
    end
    @(posedge P_clk); #1;
    sel[id]  = 1'b0;
    P_enable = 1'b0;
  endtask

  // Monitor: every P_ready cycle must match the head of the scoreboard.
  always @(negedge P_clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready dut%0d: P_ready=1 at cycle %0d, expected none", i, cyc);
        end else begin
          mon_e = sb.pop_front();
          check($sformatf("resp_dut_dut%0d", i), i, mon_e.id);
          check($sformatf("ready_cycle_dut%0d", i), cyc, mon_e.cyc);
          check($sformatf("slverr_dut%0d", i), {31'd0, err[i]}, {31'd0, mon_e.err});
          check($sformatf("rdata_dut%0d", i), rd[i], mon_e.rdata);
        end
      end
    end
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    sel = '0; P_enable = 1'b0; P_write = 1'b0;
    P_addr = '0; P_wdata = '0; P_strb = '0;
    for (int i = 0; i < 3; i++) last_rd[i] = '0;

    #2 P_reset_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_ready%0d", i),  {31'd0, rdy[i]}, 32'd0);
      check($sformatf("reset_slverr%0d", i), {31'd0, err[i]}, 32'd0);
      check($sformatf("reset_rdata%0d", i),  rd[i], 32'd0);
    end
    repeat (2) @(posedge P_clk);
    @(negedge P_clk);
    P_reset_n = 1'b1;

    // Zero wait states: write/read, byte strobes, range checks.
    xfer(0, 1, 8'd5,   32'hDEADBEEF, 4'hF, 1'b0, 32'h0);
    xfer(0, 0, 8'd5,   32'h0,        4'h0, 1'b0, 32'hDEADBEEF);
    xfer(0, 1, 8'd5,   32'h11223344, 4'h5, 1'b0, 32'h0);
    xfer(0, 0, 8'd5,   32'h0,        4'hF, 1'b0, 32'hDE22BE44);
    xfer(0, 1, 8'd5,   32'h99999999, 4'h0, 1'b0, 32'h0);
    xfer(0, 0, 8'd5,   32'h0,        4'h0, 1'b0, 32'hDE22BE44);
    xfer(0, 1, 8'd0,   32'hCAFEF00D, 4'hF, 1'b0, 32'h0);
    xfer(0, 1, 8'd63,  32'h0BADCAFE, 4'hF, 1'b0, 32'h0);
    xfer(0, 1, 8'd64,  32'hFFFFFFFF, 4'hF, 1'b1, 32'h0);
    xfer(0, 0, 8'd64,  32'h0,        4'h0, 1'b1, 32'h0);
    xfer(0, 0, 8'd63,  32'h0,        4'h0, 1'b0, 32'h0BADCAFE);
    xfer(0, 0, 8'd255, 32'h0,        4'h0, 1'b1, 32'h0);
    xfer(0, 0, 8'd0,   32'h0,        4'h0, 1'b0, 32'hCAFEF00D);

    // Three wait states: latency is checked by the monitor's cycle field.
    xfer(1, 1, 8'd10, 32'h01020304, 4'hF, 1'b0, 32'h0);
    xfer(1, 0, 8'd10, 32'h0,        4'h0, 1'b0, 32'h01020304);

    // Four wait states: seed a word, then abort a write in the second wait cycle.
    xfer(2, 1, 8'd7, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h0);
    xfer(2, 0, 8'd7, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5);
    @(posedge P_clk); #1;
    sel[2] = 1'b1; P_enable = 1'b0; P_write = 1'b1;
    P_addr = 8'd7; P_wdata = 32'h5A5A5A5A; P_strb = 4'hF;
    @(posedge P_clk); #1; P_enable = 1'b1;   // A0
    @(posedge P_clk); #1;                    // A1, first wait cycle
    @(posedge P_clk); #1; sel[2] = 1'b0;     // A2, second wait cycle
    @(posedge P_clk); #1; P_enable = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge P_clk);
      if (rdy[2] !== 1'b0) seen = 1;
    end
    check("abort_no_ready", seen, 0);
    xfer(2, 0, 8'd7, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5);

    // Reset pulse while a write waits: outputs clear at once, write dropped.
    @(posedge P_clk); #1;
    sel[2] = 1'b1; P_enable = 1'b0; P_write = 1'b1;
    P_addr = 8'd7; P_wdata = 32'h0F0F0F0F; P_strb = 4'hF;
    @(posedge P_clk); #1; P_enable = 1'b1;   // A0
    @(posedge P_clk); #1;                    // A1
    @(posedge P_clk); #1;                    // A2
    #2 P_reset_n = 1'b0;
    #1;
    check("midreset_rdata_w4",  rd[2], 32'h0);
    check("midreset_ready_w4",  {31'd0, rdy[2]}, 32'd0);
    check("midreset_slverr_w4", {31'd0, err[2]}, 32'd0);
    check("midreset_rdata_w0",  rd[0], 32'h0);
    check("midreset_rdata_w3",  rd[1], 32'h0);
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    sel = '0; P_enable = 1'b0;
    @(posedge P_clk);
    @(negedge P_clk);
    P_reset_n = 1'b1;
    xfer(2, 0, 8'd7, 32'h0, 4'h0, 1'b0, 32'hA5A5A5A5);
    xfer(0, 0, 8'd0, 32'h0, 4'h0, 1'b0, 32'hCAFEF00D);

    repeat (3) @(posedge P_clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
